btn_cmd_scheduler: RTL and testbench

BTN_CMD_SCHEDULER -- requirements
Module: btn_cmd_scheduler

---
 rtl/btn_cmd_if.sv | 9 +
 rtl/btn_cmd_scheduler.sv | 141 ++++++++++++++
 tb/tb_btn_cmd_scheduler.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_cmd_if.sv
// Command handshake between the button scheduler (master) and its consumer (slave).
interface btn_cmd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_id;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface

// File: rtl/btn_cmd_scheduler.sv
// Four debounced push-buttons turned into one-shot commands, round-robin
// arbitrated into a small FIFO with a valid/ready consumer handshake.
module btn_cmd_scheduler #(
  parameter int unsigned TICK_DIV   = 2500000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      btn,
  btn_cmd_if.master       cmd,
  output logic            drop,
  output logic            tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, HELD} state_t;

  logic [3:0]    sync1;
  logic [3:0]    sbtn;
  logic [CW-1:0] cnt;
  state_t        st [4];
  logic [3:0]    press;
  logic [3:0]    pend;
  logic [1:0]    last_grant;
  logic [1:0]    cand;
  logic [1:0]    grant_idx;
  logic          grant_vld;
  logic [3:0]    grant_oh;
  logic          pop;
  logic          full;
  logic          can_write;
  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sbtn  <= '0;
    end else begin
      sync1 <= btn;
      sbtn  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt == TICK_LAST) cnt <= '0;
    else                         cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (rst) begin
        st[i] <= IDLE;
      end else if (tick) begin
        case (st[i])
          IDLE:    if (sbtn[i]) st[i] <= ARMED;
          ARMED:   st[i] <= sbtn[i] ? HELD : IDLE;
          HELD:    if (!sbtn[i]) st[i] <= IDLE;
          default: st[i] <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    press = '0;
    for (int unsigned i = 0; i < 4; i++)
      press[i] = tick && (st[i] == ARMED) && sbtn[i];
  end

  assign pop       = cmd.cmd_valid && cmd.cmd_ready;
  assign full      = (count == FIFO_FULL);
  assign can_write = !full || pop;

  // Search starts one past the last grant; k=4 wraps back onto last_grant itself.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    cand      = last_grant;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!grant_vld && can_write && pend[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    grant_oh = grant_vld ? (4'b0001 << grant_idx) : 4'b0000;
  end

  // A press only merges (and drops) when its pend bit is not leaving this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      last_grant <= 2'd3;
      drop       <= 1'b0;
    end else begin
      pend <= (pend & ~grant_oh) | press;
      drop <= |(press & pend & ~grant_oh);
      if (grant_vld) last_grant <= grant_idx;
    end
  end

  always_comb begin
    count_next = count;
    case ({grant_vld, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      cmd.cmd_valid <= 1'b0;
    end else begin
      if (grant_vld) begin
        mem[wr_ptr] <= grant_idx;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count         <= count_next;
      cmd.cmd_valid <= (count_next != '0);
    end
  end

  assign cmd.cmd_id = mem[rd_ptr];

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// Directed bench for btn_cmd_scheduler with TICK_DIV=4, FIFO_DEPTH=4.
module tb_btn_cmd_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = '0;
  logic       drop;
  logic       tick;

  btn_cmd_if bus ();

  btn_cmd_scheduler #(.TICK_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .cmd  (bus),
    .drop (drop),
    .tick (tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] got_id [$];
  int         got_cyc [$];
  int         drop_cnt = 0;

  always @(negedge clk) begin
    if (!rst && bus.cmd_valid && bus.cmd_ready) begin
      got_id.push_back(bus.cmd_id);
      got_cyc.push_back(cyc);
    end
    if (drop === 1'b1) drop_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick;
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (tick === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL wait_tick: tick never 1 in 20 cycles (got 0, want 1)");
    end
  endtask

  task automatic do_reset;
    btn = '0;
    bus.cmd_ready = 1'b0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic press(input int i);
    wait_tick;
    btn[i] = 1'b1;
    wait_tick;
    wait_tick;
    btn[i] = 1'b0;
    wait_tick;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++; if (bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.cmd_valid); end
    n_cmp++; if (bus.cmd_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", bus.cmd_id); end
    n_cmp++; if (drop !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b want 0", drop); end
    n_cmp++; if (dut.pend !== 4'b0000) begin n_err++; $display("FAIL reset_pend: got %b want 0000", dut.pend); end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (tick !== (k == 3)) begin n_err++; $display("FAIL reset_tick_k%0d: got %b want %b", k, tick, (k == 3)); end
      step(1);
    end
  endtask

  task automatic test_single;
    int base, d0;
    do_reset;
    bus.cmd_ready = 1'b1;
    base = got_id.size();
    d0 = drop_cnt;
    wait_tick;
    btn[2] = 1'b1;
    wait_tick;
    wait_tick;
    n_cmp++; if (bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_t: got %b want 0", bus.cmd_valid); end
    step(1);
    n_cmp++; if (bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_t1: got %b want 0", bus.cmd_valid); end
    step(1);
    n_cmp++; if (bus.cmd_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_t2: got %b want 1", bus.cmd_valid); end
    n_cmp++; if (bus.cmd_id !== 2'd2) begin n_err++; $display("FAIL single_id_t2: got %0d want 2", bus.cmd_id); end
    step(1);
    n_cmp++; if (bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_t3: got %b want 0", bus.cmd_valid); end
    wait_tick;
    btn[2] = 1'b0;
    wait_tick;
    wait_tick;
    n_cmp++; if (got_id.size() - base != 1) begin n_err++; $display("FAIL single_count: got %0d want 1", got_id.size() - base); end
    n_cmp++; if (got_id.size() > base && got_id[base] !== 2'd2) begin n_err++; $display("FAIL single_cmd: got %0d want 2", got_id[base]); end
    n_cmp++; if (drop_cnt - d0 != 0) begin n_err++; $display("FAIL single_drop: got %0d want 0", drop_cnt - d0); end
  endtask

  task automatic test_bounce;
    int base, d0;
    do_reset;
    bus.cmd_ready = 1'b1;
    base = got_id.size();
    d0 = drop_cnt;
    wait_tick;
    step(2);
    btn[1] = 1'b1;
    step(1);
    btn[1] = 1'b0;
    wait_tick;
    n_cmp++; if (dut.sbtn[1] !== 1'b1) begin n_err++; $display("FAIL bounce_captured: got %b want 1", dut.sbtn[1]); end
    wait_tick;
    wait_tick;
    wait_tick;
    n_cmp++; if (bus.cmd_valid !== 1'b0) begin n_err++; $display("FAIL bounce_valid: got %b want 0", bus.cmd_valid); end
    n_cmp++; if (got_id.size() - base != 0) begin n_err++; $display("FAIL bounce_count: got %0d want 0", got_id.size() - base); end
    n_cmp++; if (drop_cnt - d0 != 0) begin n_err++; $display("FAIL bounce_drop: got %0d want 0", drop_cnt - d0); end
  endtask

  task automatic test_simultaneous;
    int base, t_ev;
    do_reset;
    bus.cmd_ready = 1'b1;
    base = got_id.size();
    wait_tick;
    btn = 4'b1111;
    wait_tick;
    wait_tick;
    t_ev = cyc;
    step(8);
    btn = '0;
    wait_tick;
    wait_tick;
    n_cmp++; if (got_id.size() - base != 4) begin n_err++; $display("FAIL simul_count: got %0d want 4", got_id.size() - base); end
    for (int k = 0; k < 4; k++) begin
      if (base + k < got_id.size()) begin
        n_cmp++;
        if (got_id[base + k] !== 2'(k)) begin n_err++; $display("FAIL simul_id%0d: got %0d want %0d", k, got_id[base + k], k); end
        n_cmp++;
        if (got_cyc[base + k] != t_ev + 2 + k) begin n_err++; $display("FAIL simul_cyc%0d: got %0d want %0d", k, got_cyc[base + k], t_ev + 2 + k); end
      end
    end
  endtask

  task automatic test_back_to_back;
    int base, d0;
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset;
    base = got_id.size();
    d0 = drop_cnt;
    for (int i = 0; i < 4; i++) begin
      press(i);
      n_cmp++; if (bus.cmd_id !== 2'd0) begin n_err++; $display("FAIL bp_id_after%0d: got %0d want 0", i, bus.cmd_id); end
    end
    press(0);
    n_cmp++; if (bus.cmd_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", bus.cmd_valid); end
    n_cmp++; if (bus.cmd_id !== 2'd0) begin n_err++; $display("FAIL bp_id: got %0d want 0", bus.cmd_id); end
    n_cmp++; if (dut.pend !== 4'b0001) begin n_err++; $display("FAIL bp_pend: got %b want 0001", dut.pend); end
    n_cmp++; if (got_id.size() - base != 0) begin n_err++; $display("FAIL bp_nopop: got %0d want 0", got_id.size() - base); end
    bus.cmd_ready = 1'b1;
    step(10);
    n_cmp++; if (got_id.size() - base != 5) begin n_err++; $display("FAIL bp_count: got %0d want 5", got_id.size() - base); end
    for (int k = 0; k < 5; k++) begin
      if (base + k < got_id.size()) begin
        n_cmp++;
        if (got_id[base + k] !== exp_seq[k]) begin n_err++; $display("FAIL bp_seq%0d: got %0d want %0d", k, got_id[base + k], exp_seq[k]); end
      end
    end
    n_cmp++; if (drop_cnt - d0 != 0) begin n_err++; $display("FAIL bp_drop: got %0d want 0", drop_cnt - d0); end
  endtask

  task automatic test_merge;
    int base, d0;
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    do_reset;
    base = got_id.size();
    d0 = drop_cnt;
    for (int i = 0; i < 4; i++) press(i);
    press(1);
    n_cmp++; if (drop_cnt - d0 != 0) begin n_err++; $display("FAIL merge_drop_first: got %0d want 0", drop_cnt - d0); end
    press(1);
    n_cmp++; if (drop_cnt - d0 != 1) begin n_err++; $display("FAIL merge_drop_second: got %0d want 1", drop_cnt - d0); end
    bus.cmd_ready = 1'b1;
    step(10);
    n_cmp++; if (got_id.size() - base != 5) begin n_err++; $display("FAIL merge_count: got %0d want 5", got_id.size() - base); end
    for (int k = 0; k < 5; k++) begin
      if (base + k < got_id.size()) begin
        n_cmp++;
        if (got_id[base + k] !== exp_seq[k]) begin n_err++; $display("FAIL merge_seq%0d: got %0d want %0d", k, got_id[base + k], exp_seq[k]); end
      end
    end
    n_cmp++; if (drop_cnt - d0 != 1) begin n_err++; $display("FAIL merge_drop_total: got %0d want 1", drop_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    int base;
    do_reset;
    press(0);
    press(1);
    press(2);
    wait_tick;
    btn[3] = 1'b1;
    wait_tick;
    wait_tick;
    step(2);
    n_cmp++; if (bus.cmd_valid !== 1'b1) begin n_err++; $display("FAIL rmid_prevalid: got %b want 1", bus.cmd_valid); end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    bus.cmd_ready = 1'b1;
    base = got_id.size();
    for (int k = 1; k <= 11; k++) begin
      n_cmp++;
      if (tick !== (k == 4 || k == 8)) begin n_err++; $display("FAIL rmid_tick_k%0d: got %b want %b", k, tick, (k == 4 || k == 8)); end
      n_cmp++;
      if (bus.cmd_valid !== (k == 10)) begin n_err++; $display("FAIL rmid_valid_k%0d: got %b want %b", k, bus.cmd_valid, (k == 10)); end
      if (k == 10) begin
        n_cmp++;
        if (bus.cmd_id !== 2'd3) begin n_err++; $display("FAIL rmid_id: got %0d want 3", bus.cmd_id); end
      end
      step(1);
    end
    btn = '0;
    wait_tick;
    wait_tick;
    n_cmp++; if (got_id.size() - base != 1) begin n_err++; $display("FAIL rmid_count: got %0d want 1", got_id.size() - base); end
    n_cmp++; if (got_id.size() > base && got_id[base] !== 2'd3) begin n_err++; $display("FAIL rmid_cmd: got %0d want 3", got_id[base]); end
  endtask

  initial begin
    bus.cmd_ready = 1'b0;
    test_reset;
    test_single;
    test_bounce;
    test_simultaneous;
    test_back_to_back;
    test_merge;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, want completion)");
    $fatal(1, "watchdog");
  end
endmodule
